// File: rtl/uart_pkg.sv
// Shared UART definitions: byte-FSM state encoding and the bit-period divisor.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Clocks per bit, truncated: (clk_mhz * 1e6) / baud
    function automatic int unsigned uart_div(input int unsigned clk_mhz,
                                             input int unsigned baud);
        longint unsigned hz;
        hz = 64'(clk_mhz) * 64'd1000000;
        return 32'(hz / 64'(baud));
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop line synchronizer, start/data/stop FSM, bit timer.
// Stop-bit results are combinational strobes so the word layer can register
// its outputs in the cycle right after the stop sample.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLK_RATE = 50,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_srx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int unsigned DIV  = uart_div(CLK_RATE, BAUD);
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned TW   = $clog2(DIV + 1);
    localparam logic [TW-1:0] DIV_LAST  = TW'(DIV - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [1:0]    r_flush;
    logic          r_armed;
    uart_state_e   r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;

    logic          w_fall;
    logic          w_stop_tick;

    // A start edge only counts once the line has been seen high after reset,
    // so a line held low through reset release cannot fake a frame.
    assign w_fall      = r_armed & r_prev & ~r_sync2;
    assign w_stop_tick = (r_state == ST_STOP) && (r_timer == DIV_LAST);

    assign o_byte_valid = w_stop_tick & r_sync2;
    assign o_frame_err  = w_stop_tick & ~r_sync2;
    assign o_byte       = r_shift;
    assign o_busy       = (r_state != ST_IDLE);

    // Synchronize the line, keep its previous value, and arm after a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_flush <= 2'd0;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= i_srx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_flush != 2'd2) begin
                r_flush <= r_flush + 2'd1;
            end else if (r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Byte FSM: mid-bit sampling of start, 8 data bits LSB first, stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    if (w_fall) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_timer == HALF_LAST) begin
                        r_timer   <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= r_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (r_timer == DIV_LAST) begin
                        r_timer <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (r_timer == DIV_LAST) begin
                        r_timer <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_word.sv
// UART word receiver: packs four received bytes big-endian into a 32-bit word,
// pulses ready on completion, and drops a stale partial word after a long idle.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int unsigned CLK_RATE      = 50,
    parameter int unsigned BAUD          = 115200,
    parameter int unsigned TIMEOUT_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srx,
    output logic        ready,
    output logic [31:0] rx_word,
    output logic        frame_err
);

    localparam int unsigned DIV = uart_div(CLK_RATE, BAUD);
    localparam int unsigned TMO = TIMEOUT_BYTES * 10 * DIV;
    localparam int unsigned TOW = $clog2(TMO + 1);
    localparam logic [TOW-1:0] TMO_LAST = TOW'(TMO - 1);

    logic           w_byte_valid;
    logic [7:0]     w_byte;
    logic           w_frame_err;
    logic           w_busy;
    logic           w_timeout;

    logic [1:0]     r_byte_cnt;
    logic [23:0]    r_partial;
    logic [TOW-1:0] r_idle_cnt;

    uart_rx_byte #(
        .CLK_RATE (CLK_RATE),
        .BAUD     (BAUD)
    ) u_byte (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_srx        (srx),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_frame_err  (w_frame_err),
        .o_busy       (w_busy)
    );

    assign w_timeout = (r_byte_cnt != 2'd0) && !w_busy && (r_idle_cnt == TMO_LAST);

    // Count idle clocks while a partial word is pending and no frame is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if ((r_byte_cnt == 2'd0) || w_busy || w_byte_valid || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + TOW'(1);
        end
    end

    // Assemble bytes MSB-first; publish the word and single-cycle strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= 2'd0;
            r_partial  <= 24'd0;
            rx_word    <= 32'd0;
            ready      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            ready     <= 1'b0;
            frame_err <= 1'b0;
            if (w_frame_err) begin
                frame_err  <= 1'b1;
                r_byte_cnt <= 2'd0;
            end else if (w_byte_valid) begin
                if (r_byte_cnt == 2'd3) begin
                    rx_word <= {r_partial, w_byte};
                    ready   <= 1'b1;
                end else begin
                    r_partial <= {r_partial[15:0], w_byte};
                end
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end else if (w_timeout) begin
                r_byte_cnt <= 2'd0;
            end
        end
    end

endmodule
